// File: rtl/sr_flag_bank.sv
// rtl/sr_flag_bank.sv - multi-channel set/reset flag bank
// Per-channel flags with set/reset priority, optional edge set, auto-clear hold timer and first-set capture.
module sr_flag_bank #(
  parameter int N_CH         = 4,
  parameter int SET_DOMINANT = 1,
  parameter int EDGE_SET     = 0,
  parameter int HOLD_CYCLES  = 0,
  localparam int CW = $clog2(N_CH + 1),
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] set,
  input  logic [N_CH-1:0] reset,
  input  logic            clear_all,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] expired,
  output logic            any,
  output logic [CW-1:0]   count,
  output logic [IW-1:0]   first_idx,
  output logic            first_valid
);

  logic [N_CH-1:0] set_d;
  logic [N_CH-1:0] set_eff;
  logic [N_CH-1:0] win_set;
  logic [N_CH-1:0] win_rst;
  logic [N_CH-1:0] tmo_raw;
  logic [N_CH-1:0] out_nxt;
  logic [N_CH-1:0] rises;
  logic [IW-1:0]   first_lo;

  assign set_eff = (EDGE_SET != 0) ? (set & ~set_d) : set;
  assign win_set = (SET_DOMINANT != 0) ? set_eff : (set_eff & ~reset);
  assign win_rst = reset & ~win_set;
  // A winning set beats a pending timeout; an explicit reset or timeout clears.
  assign out_nxt = (out & ~win_rst & ~tmo_raw) | win_set;
  assign rises   = out_nxt & ~out;

  always_comb begin
    first_lo = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rises[i]) first_lo = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out         <= '0;
      set_d       <= '0;
      first_idx   <= '0;
      first_valid <= 1'b0;
    end else begin
      set_d <= set;
      if (clear_all) begin
        out         <= '0;
        first_idx   <= '0;
        first_valid <= 1'b0;
      end else begin
        out <= out_nxt;
        if (!first_valid && (|rises)) begin
          first_idx   <= first_lo;
          first_valid <= 1'b1;
        end
      end
    end
  end

  generate
    if (HOLD_CYCLES > 0) begin : g_hold
      localparam int TW = $clog2(HOLD_CYCLES + 1);
      logic [N_CH-1:0][TW-1:0] timer;
      logic [N_CH-1:0]         expired_q;

      always_comb begin
        tmo_raw = '0;
        for (int i = 0; i < N_CH; i++) begin
          tmo_raw[i] = out[i] && (timer[i] == TW'(1));
        end
      end

      always_ff @(posedge clk) begin
        if (rst || clear_all) begin
          timer     <= '0;
          expired_q <= '0;
        end else begin
          expired_q <= tmo_raw & ~win_set & ~win_rst;
          for (int i = 0; i < N_CH; i++) begin
            if (win_set[i])
              timer[i] <= TW'(HOLD_CYCLES);
            else if (win_rst[i])
              timer[i] <= '0;
            else if (out[i] && (timer[i] != '0))
              timer[i] <= timer[i] - TW'(1);
          end
        end
      end

      assign expired = expired_q;
    end else begin : g_no_hold
      assign tmo_raw = '0;
      assign expired = '0;
    end
  endgenerate

  assign any = |out;

  always_comb begin
    count = '0;
    for (int i = 0; i < N_CH; i++) begin
      count = count + CW'(out[i]);
    end
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
// tb/tb_sr_flag_bank.sv - directed self-checking bench for sr_flag_bank
// Four instances share stimulus: level/set-dominant, reset-dominant, edge-set, and hold-timer variants.
module tb_sr_flag_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] set = '0;
  logic [3:0] reset = '0;
  logic       clear_all = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [3:0] a_out, a_exp, b_out, b_exp, c_out, c_exp, d_out, d_exp;
  logic       a_any, b_any, c_any, d_any;
  logic [2:0] a_cnt, b_cnt, c_cnt, d_cnt;
  logic [1:0] a_fi, b_fi, c_fi, d_fi;
  logic       a_fv, b_fv, c_fv, d_fv;

  always #5 clk = ~clk;

  sr_flag_bank #(.N_CH(4), .SET_DOMINANT(1), .EDGE_SET(0), .HOLD_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .set(set), .reset(reset), .clear_all(clear_all),
    .out(a_out), .expired(a_exp), .any(a_any), .count(a_cnt), .first_idx(a_fi), .first_valid(a_fv));

  sr_flag_bank #(.N_CH(4), .SET_DOMINANT(0), .EDGE_SET(0), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .set(set), .reset(reset), .clear_all(clear_all),
    .out(b_out), .expired(b_exp), .any(b_any), .count(b_cnt), .first_idx(b_fi), .first_valid(b_fv));

  sr_flag_bank #(.N_CH(4), .SET_DOMINANT(1), .EDGE_SET(1), .HOLD_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .set(set), .reset(reset), .clear_all(clear_all),
    .out(c_out), .expired(c_exp), .any(c_any), .count(c_cnt), .first_idx(c_fi), .first_valid(c_fv));

  sr_flag_bank #(.N_CH(4), .SET_DOMINANT(1), .EDGE_SET(0), .HOLD_CYCLES(5)) dut_d (
    .clk(clk), .rst(rst), .set(set), .reset(reset), .clear_all(clear_all),
    .out(d_out), .expired(d_exp), .any(d_any), .count(d_cnt), .first_idx(d_fi), .first_valid(d_fv));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    set = '0; reset = '0; clear_all = 1'b1;
    step();
    clear_all = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; set = 4'hF; reset = '0;
    step(); step();
    total++; if (a_out !== 4'b0000) begin bad++; $display("FAIL rst_out got=%0h exp=0", a_out); end
    total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", a_cnt); end
    total++; if (a_fv !== 1'b0) begin bad++; $display("FAIL rst_first_valid got=%0b exp=0", a_fv); end
    total++; if (a_any !== 1'b0) begin bad++; $display("FAIL rst_any got=%0b exp=0", a_any); end
    total++; if (d_exp !== 4'b0000) begin bad++; $display("FAIL rst_expired got=%0h exp=0", d_exp); end
    rst = 1'b0; set = 4'b0100;
    step();
    set = '0;
    total++; if (a_out !== 4'b0100) begin bad++; $display("FAIL lat_out got=%0h exp=4", a_out); end
    total++; if (a_any !== 1'b1) begin bad++; $display("FAIL lat_any got=%0b exp=1", a_any); end
    total++; if (a_cnt !== 3'd1) begin bad++; $display("FAIL lat_count got=%0d exp=1", a_cnt); end
    total++; if (a_fi !== 2'd2) begin bad++; $display("FAIL lat_first_idx got=%0d exp=2", a_fi); end
    total++; if (a_fv !== 1'b1) begin bad++; $display("FAIL lat_first_valid got=%0b exp=1", a_fv); end
  endtask

  task automatic test_priority();
    do_clear();
    set = 4'b0011; reset = 4'b0011;
    step();
    set = '0; reset = '0;
    total++; if (a_out !== 4'b0011) begin bad++; $display("FAIL prio_setdom got=%0h exp=3", a_out); end
    total++; if (b_out !== 4'b0000) begin bad++; $display("FAIL prio_rstdom got=%0h exp=0", b_out); end
    total++; if (a_cnt !== 3'd2) begin bad++; $display("FAIL prio_count got=%0d exp=2", a_cnt); end
    clear_all = 1'b1; set = 4'hF;
    step();
    clear_all = 1'b0; set = '0;
    total++; if (a_out !== 4'b0000) begin bad++; $display("FAIL clear_out got=%0h exp=0", a_out); end
    total++; if (a_fv !== 1'b0) begin bad++; $display("FAIL clear_first_valid got=%0b exp=0", a_fv); end
    total++; if (b_out !== 4'b0000) begin bad++; $display("FAIL clear_out_b got=%0h exp=0", b_out); end
  endtask

  task automatic test_edge();
    do_clear();
    for (int k = 0; k < 10; k++) begin
      set = 4'b0001;
      reset = (k == 4) ? 4'b0001 : 4'b0000;
      step();
      total++;
      if (c_out[0] !== (k < 4)) begin
        bad++; $display("FAIL edge_hold_%0d got=%0b exp=%0b", k, c_out[0], (k < 4));
      end
    end
    reset = '0; set = '0;
    step();
    total++; if (c_out[0] !== 1'b0) begin bad++; $display("FAIL edge_fall got=%0b exp=0", c_out[0]); end
    set = 4'b0001;
    step();
    set = '0;
    total++; if (c_out[0] !== 1'b1) begin bad++; $display("FAIL edge_rerise got=%0b exp=1", c_out[0]); end
  endtask

  task automatic test_timeout();
    do_clear();
    for (int k = 0; k < 7; k++) begin
      set = (k == 0) ? 4'b0010 : 4'b0000;
      step();
      total++; if (d_out[1] !== (k < 5)) begin bad++; $display("FAIL tmo_out_%0d got=%0b exp=%0b", k, d_out[1], (k < 5)); end
      total++; if (d_exp[1] !== (k == 5)) begin bad++; $display("FAIL tmo_exp_%0d got=%0b exp=%0b", k, d_exp[1], (k == 5)); end
    end
    do_clear();
    for (int k = 0; k < 10; k++) begin
      set = (k == 0 || k == 3) ? 4'b0010 : 4'b0000;
      step();
      total++; if (d_out[1] !== (k < 8)) begin bad++; $display("FAIL retrig_out_%0d got=%0b exp=%0b", k, d_out[1], (k < 8)); end
      total++; if (d_exp[1] !== (k == 8)) begin bad++; $display("FAIL retrig_exp_%0d got=%0b exp=%0b", k, d_exp[1], (k == 8)); end
    end
    do_clear();
    for (int k = 0; k < 8; k++) begin
      set   = (k == 0) ? 4'b0010 : 4'b0000;
      reset = (k == 2) ? 4'b0010 : 4'b0000;
      step();
      total++; if (d_out[1] !== (k < 2)) begin bad++; $display("FAIL rstmid_out_%0d got=%0b exp=%0b", k, d_out[1], (k < 2)); end
      total++; if (d_exp !== 4'b0000) begin bad++; $display("FAIL rstmid_exp_%0d got=%0h exp=0", k, d_exp); end
    end
    reset = '0;
  endtask

  task automatic test_first_capture();
    do_clear();
    set = 4'b1010;
    step();
    set = '0;
    total++; if (a_fi !== 2'd1) begin bad++; $display("FAIL first_tie got=%0d exp=1", a_fi); end
    total++; if (a_fv !== 1'b1) begin bad++; $display("FAIL first_tie_valid got=%0b exp=1", a_fv); end
    set = 4'b0001;
    step();
    set = '0;
    total++; if (a_fi !== 2'd1) begin bad++; $display("FAIL first_hold got=%0d exp=1", a_fi); end
    total++; if (a_out !== 4'b1011) begin bad++; $display("FAIL first_out got=%0h exp=b", a_out); end
    total++; if (a_cnt !== 3'd3) begin bad++; $display("FAIL first_count got=%0d exp=3", a_cnt); end
    do_clear();
    total++; if (a_fv !== 1'b0) begin bad++; $display("FAIL first_cleared got=%0b exp=0", a_fv); end
    set = 4'b1000;
    step();
    set = '0;
    total++; if (a_fi !== 2'd3) begin bad++; $display("FAIL first_after_clear got=%0d exp=3", a_fi); end
    total++; if (a_fv !== 1'b1) begin bad++; $display("FAIL first_after_valid got=%0b exp=1", a_fv); end
  endtask

  task automatic test_rst_mid();
    do_clear();
    set = 4'b0111;
    step();
    set = '0;
    step();
    total++; if (d_out !== 4'b0111) begin bad++; $display("FAIL rstop_pre got=%0h exp=7", d_out); end
    rst = 1'b1;
    step();
    total++; if (d_out !== 4'b0000) begin bad++; $display("FAIL rstop_out got=%0h exp=0", d_out); end
    total++; if (d_cnt !== 3'd0) begin bad++; $display("FAIL rstop_count got=%0d exp=0", d_cnt); end
    total++; if (d_exp !== 4'b0000) begin bad++; $display("FAIL rstop_exp got=%0h exp=0", d_exp); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      total++; if (d_exp !== 4'b0000 || d_out !== 4'b0000) begin
        bad++; $display("FAIL rstop_post_%0d got=%0h/%0h exp=0/0", k, d_out, d_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_edge();
    test_timeout();
    test_first_capture();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
